cam_capture_ctrl: RTL
=====================

// Module: cam_capture_ctrl
// PURPOSE
//  Frame-capture sequencer between OV7670 timing and the DP_RAM write port.
//  Arms on a start command and aligns to frame boundaries (CAM_vsync).
//  Gates the byte packer (cap_en), issues DP_RAM write strobes/addresses per packed pixel.
//  Checks frame geometry; supports single-shot and continuous capture with status/frame count.
// PARAMETERS
//  AW      15    DP_RAM address width
//  IMG_W   160   pixels per line
//  IMG_H   120   lines per frame (PIX_TOTAL = IMG_W*IMG_H = 19200)
//  FCW     8     frame counter width
// PORTS
//  CAM_pclk        in   1      sole clock; all inputs synchronous to it
//  rst             in   1      asynchronous, active-high reset
//  CAM_vsync       in   1      camera vsync (high = blanking/frame boundary)
//  CAM_href        in   1      camera line valid
//  start           in   1      1-cycle pulse: arm capture
//  stop            in   1      1-cycle pulse: end after current frame
//  mode_cont       in   1      0 single-shot, 1 continuous (sampled at start)
//  px_valid        in   1      packer has a complete 12-bit pixel this cycle
//  cap_en          out  1      enable to packer
//  DP_RAM_regW     out  1      write strobe
//  DP_RAM_addr_in  out  AW     write address
//  busy            out  1      state != IDLE
//  frame_done      out  1      1-cycle pulse, good frame
//  frame_err       out  1      1-cycle pulse, bad frame
//  frame_cnt       out  FCW    good frames since reset, wraps
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; col/row/pix counters 0; flags cleared. Takes effect mid-frame immediately.
//  Edges: vs_q/hr_q registered copies; vs_rise = CAM_vsync&~vs_q, vs_fall = ~CAM_vsync&vs_q, hr_fall = ~CAM_href&hr_q.
//  FSM:
//   IDLE  : start&~stop -> ARM (latch mode_cont, clear stop_pend). start&stop same cycle -> stay IDLE.
//   ARM   : vs_rise -> SYNC (never capture a frame already in progress).
//   SYNC  : vs_fall -> CAPT; clear pix/col/row counters and err flag.
//   CAPT  : cap_en = CAM_href & ~CAM_vsync (combinational from inputs).
//           px_valid -> next cycle DP_RAM_regW=1 with DP_RAM_addr_in = pix; then pix++.
//           Latency px_valid -> regW: exactly 1 cycle. regW is a 1-cycle pulse per pixel.
//           col++ per px_valid. On hr_fall: if col != IMG_W, set err. Then col=0, row++.
//           Overflow: px_valid with pix == PIX_TOTAL: no regW, pix holds, err set.
//           vs_rise -> END.
//   END   : one cycle.
//           If ~err & pix==PIX_TOTAL & row==IMG_H: frame_done=1, frame_cnt++.
//           Otherwise frame_err=1.
//           Next state: cont & ~stop_pend -> SYNC, else IDLE.
//  stop in ARM/SYNC -> IDLE immediately. stop in CAPT/END -> set stop_pend; current frame completes.
//  start while busy: ignored.
//  px_valid outside CAPT: ignored.
//  DP_RAM_addr_in holds last written address between strobes.
//  No pixel is ever written to an address >= PIX_TOTAL.
//  frame_cnt wraps 2^FCW-1 -> 0.
// STRUCTURE
//  cam_pkg: state encoding (IDLE,ARM,SYNC,CAPT,END), IMG_W/IMG_H/PIX_TOTAL constants.
//  Sub-module cam_sync_edge: registers vsync/href; emits vs_rise/vs_fall/hr_fall.
//  Top: FSM, counters, write-strobe register.
// TESTING
//  1 Assert rst mid-CAPT -> all outputs 0 asynchronously; busy=0; frame_cnt=0.
//  2 start (single), one 160x120 frame -> 19200 regW pulses, addr 0..19199 in order.
//    Then frame_done one pulse, frame_cnt=1, busy=0.
//  3 start asserted while vsync low mid-frame -> no regW until the next vs_fall.
//    Next frame captured in full.
//  4 Continuous mode, stop during frame 2 -> frames 1,2 done, frame_cnt=2.
//    No regW in frame 3; back to IDLE.
//  5 Row 5 has only 159 pixels -> frame_err pulse, frame_done=0, frame_cnt unchanged.
//  6 Frame with 19201 px_valid -> 19200 regW pulses; last addr 19199; frame_err pulse.

Source files
------------

// File: rtl/cam_capture_ctrl_pkg.sv
// cam_capture_ctrl_pkg: shared state encoding and default frame geometry for the capture sequencer
package cam_capture_ctrl_pkg;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int PIX_TOTAL = IMG_W * IMG_H;
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_CAPT, S_END} state_e;
endpackage

// File: rtl/cam_capture_ctrl_if.sv
// cam_capture_ctrl_if: camera timing, control, packer and DP_RAM write-port signals of the capture sequencer
interface cam_capture_ctrl_if #(
  parameter int AW = 15,
  parameter int FCW = 8
);
  logic CAM_vsync;
  logic CAM_href;
  logic start;
  logic stop;
  logic mode_cont;
  logic px_valid;
  logic cap_en;
  logic DP_RAM_regW;
  logic [AW-1:0] DP_RAM_addr_in;
  logic busy;
  logic frame_done;
  logic frame_err;
  logic [FCW-1:0] frame_cnt;
  modport master (
    output CAM_vsync, CAM_href, start, stop, mode_cont, px_valid,
    input cap_en, DP_RAM_regW, DP_RAM_addr_in, busy, frame_done, frame_err, frame_cnt
  );
  modport slave (
    input CAM_vsync, CAM_href, start, stop, mode_cont, px_valid,
    output cap_en, DP_RAM_regW, DP_RAM_addr_in, busy, frame_done, frame_err, frame_cnt
  );
endinterface

// File: rtl/cam_capture_ctrl_sync_edge.sv
// cam_capture_ctrl_sync_edge: registers vsync/href and flags their frame/line boundary edges
module cam_capture_ctrl_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic vsync_i,
  input  logic href_i,
  output logic vs_rise_o,
  output logic vs_fall_o,
  output logic hr_fall_o
);
  logic vs_q;
  logic hr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q <= 1'b0;
      hr_q <= 1'b0;
    end else begin
      vs_q <= vsync_i;
      hr_q <= href_i;
    end
  end
  assign vs_rise_o = vsync_i & ~vs_q;
  assign vs_fall_o = ~vsync_i & vs_q;
  assign hr_fall_o = ~href_i & hr_q;
endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: frame-aligned capture sequencer driving the DP_RAM write port from packed camera pixels
module cam_capture_ctrl
  import cam_capture_ctrl_pkg::*;
#(
  parameter int AW = 15,
  parameter int IMG_W = cam_capture_ctrl_pkg::IMG_W,
  parameter int IMG_H = cam_capture_ctrl_pkg::IMG_H,
  parameter int FCW = 8
) (
  input logic CAM_pclk,
  input logic rst,
  cam_capture_ctrl_if.slave bus
);
  localparam int PIX_N = IMG_W * IMG_H;
  localparam int PW = $clog2(PIX_N + 1);
  localparam int CW = $clog2(IMG_W + 2);
  localparam int RW = $clog2(IMG_H + 2);
  localparam logic [PW-1:0] PT = PW'(PIX_N);
  localparam logic [CW-1:0] WL = CW'(IMG_W);
  localparam logic [CW-1:0] WS = CW'(IMG_W + 1);
  localparam logic [RW-1:0] HL = RW'(IMG_H);
  localparam logic [RW-1:0] HS = RW'(IMG_H + 1);
  state_e state_q, state_d;
  logic cont_q, cont_d;
  logic stop_pend_q, stop_pend_d;
  logic err_q, err_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [CW-1:0] col_q, col_d, col_inc;
  logic [RW-1:0] row_q, row_d;
  logic regw_q;
  logic [AW-1:0] addr_q;
  logic [FCW-1:0] cnt_q;
  logic vs_rise, vs_fall, hr_fall;
  logic capt, wr, good;
  cam_capture_ctrl_sync_edge u_edge (
    .clk(CAM_pclk),
    .rst(rst),
    .vsync_i(bus.CAM_vsync),
    .href_i(bus.CAM_href),
    .vs_rise_o(vs_rise),
    .vs_fall_o(vs_fall),
    .hr_fall_o(hr_fall)
  );
  assign capt = state_q == S_CAPT;
  // pix saturates at PIX_N so an overlong frame can never address past the buffer
  assign wr = capt & bus.px_valid & (pix_q != PT);
  assign good = ~err_q & (pix_q == PT) & (row_q == HL);
  // col/row saturate one past nominal so a runaway line cannot wrap back to a legal count
  assign col_inc = (bus.px_valid && col_q != WS) ? col_q + 1'b1 : col_q;
  always_comb begin
    state_d = state_q;
    cont_d = cont_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      S_IDLE: if (bus.start && !bus.stop) begin
        state_d = S_ARM;
        cont_d = bus.mode_cont;
        stop_pend_d = 1'b0;
      end
      S_ARM: state_d = bus.stop ? S_IDLE : vs_rise ? S_SYNC : S_ARM;
      S_SYNC: state_d = bus.stop ? S_IDLE : vs_fall ? S_CAPT : S_SYNC;
      S_CAPT: begin
        stop_pend_d = stop_pend_q | bus.stop;
        state_d = vs_rise ? S_END : S_CAPT;
      end
      S_END: begin
        stop_pend_d = stop_pend_q | bus.stop;
        state_d = (cont_q && !stop_pend_d) ? S_SYNC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    pix_d = pix_q;
    col_d = col_q;
    row_d = row_q;
    err_d = err_q;
    if (state_q == S_SYNC && vs_fall) begin
      pix_d = '0;
      col_d = '0;
      row_d = '0;
      err_d = 1'b0;
    end else if (capt) begin
      pix_d = wr ? pix_q + 1'b1 : pix_q;
      err_d = err_q | (bus.px_valid & ~wr) | (hr_fall & (col_inc != WL));
      col_d = hr_fall ? '0 : col_inc;
      row_d = (hr_fall && row_q != HS) ? row_q + 1'b1 : row_q;
    end
  end
  always_ff @(posedge CAM_pclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cont_q <= 1'b0;
      stop_pend_q <= 1'b0;
      err_q <= 1'b0;
      pix_q <= '0;
      col_q <= '0;
      row_q <= '0;
      regw_q <= 1'b0;
      addr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cont_q <= cont_d;
      stop_pend_q <= stop_pend_d;
      err_q <= err_d;
      pix_q <= pix_d;
      col_q <= col_d;
      row_q <= row_d;
      regw_q <= wr;
      addr_q <= wr ? AW'(pix_q) : addr_q;
      cnt_q <= (state_q == S_END && good) ? cnt_q + 1'b1 : cnt_q;
    end
  end
  assign bus.cap_en = capt & bus.CAM_href & ~bus.CAM_vsync;
  assign bus.DP_RAM_regW = regw_q;
  assign bus.DP_RAM_addr_in = addr_q;
  assign bus.busy = state_q != S_IDLE;
  assign bus.frame_done = (state_q == S_END) & good;
  assign bus.frame_err = (state_q == S_END) & ~good;
  assign bus.frame_cnt = cnt_q;
endmodule
